// File: rtl/conv2_sched.sv
// conv2_sched: raster-order window/tap sequencer for the 2-D convolution datapath.
// Issues per-tap image/kernel reads, MAC strobes, and one handshaked write per window.
module conv2_sched #(
    parameter  int unsigned SIZE      = 320,
    parameter  int unsigned SIZEKer   = 3,
    parameter  int unsigned WIDTH_BIT = 16,
    localparam int unsigned OUT       = SIZE - SIZEKer + 1,
    localparam int unsigned IMG_AW    = ($clog2(SIZE * SIZE) > 1) ? $clog2(SIZE * SIZE) : 1,
    localparam int unsigned KER_AW    = ($clog2(SIZEKer * SIZEKer) > 1) ? $clog2(SIZEKer * SIZEKer) : 1,
    localparam int unsigned OUT_AW    = ($clog2(OUT * OUT) > 1) ? $clog2(OUT * OUT) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [IMG_AW-1:0] img_addr,
    output logic [KER_AW-1:0] ker_addr,
    output logic              mac_en,
    output logic              mac_first,
    output logic              out_we,
    output logic [OUT_AW-1:0] out_addr,
    input  logic              out_ready
);

    localparam int unsigned RW = ($clog2(OUT) > 1) ? $clog2(OUT) : 1;
    localparam int unsigned TW = ($clog2(SIZEKer) > 1) ? $clog2(SIZEKer) : 1;

    if (SIZEKer < 1 || SIZE < SIZEKer || WIDTH_BIT < 1) begin : g_param_check
        $error("conv2_sched: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [RW-1:0] r, c, r_nx, c_nx;
    logic [TW-1:0] i, j, i_nx, j_nx;
    logic          last_j, last_i, last_c, last_r;

    assign last_j = (j == TW'(SIZEKer - 1));
    assign last_i = (i == TW'(SIZEKer - 1));
    assign last_c = (c == RW'(OUT - 1));
    assign last_r = (r == RW'(OUT - 1));

    // State and window/tap counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            r     <= '0;
            c     <= '0;
            i     <= '0;
            j     <= '0;
        end else begin
            state <= state_nx;
            r     <= r_nx;
            c     <= c_nx;
            i     <= i_nx;
            j     <= j_nx;
        end
    end

    // MAC strobes trail the read strobe by the one-cycle memory latency
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mac_en    <= 1'b0;
            mac_first <= 1'b0;
        end else begin
            mac_en    <= rd_en;
            mac_first <= rd_en && (i == '0) && (j == '0);
        end
    end

    always_comb begin
        state_nx = state;
        r_nx     = r;
        c_nx     = c;
        i_nx     = i;
        j_nx     = j;
        busy     = 1'b0;
        done     = 1'b0;
        rd_en    = 1'b0;
        out_we   = 1'b0;
        img_addr = '0;
        ker_addr = '0;
        out_addr = '0;
        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start) begin
                    state_nx = S_READ;
                    r_nx     = '0;
                    c_nx     = '0;
                    i_nx     = '0;
                    j_nx     = '0;
                end
            end
            S_READ: begin
                busy     = 1'b1;
                rd_en    = 1'b1;
                img_addr = IMG_AW'((32'(r) + 32'(i)) * SIZE + 32'(c) + 32'(j));
                ker_addr = KER_AW'(32'(i) * SIZEKer + 32'(j));
                if (last_j) begin
                    j_nx = '0;
                    if (last_i) begin
                        i_nx     = '0;
                        state_nx = S_WAIT;
                    end else begin
                        i_nx = i + TW'(1);
                    end
                end else begin
                    j_nx = j + TW'(1);
                end
            end
            S_WAIT: begin
                busy     = 1'b1;
                state_nx = S_WRITE;
            end
            S_WRITE: begin
                busy     = 1'b1;
                out_we   = 1'b1;
                out_addr = OUT_AW'(32'(r) * OUT + 32'(c));
                if (out_ready) begin
                    if (last_r && last_c) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_READ;
                        if (last_c) begin
                            c_nx = '0;
                            r_nx = r + RW'(1);
                        end else begin
                            c_nx = c + RW'(1);
                        end
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv2_sched.sv
// Scoreboard bench for conv2_sched: a timeline model predicts every read, MAC, write and done
// event with its cycle; a negedge monitor pops and compares whatever the DUTs present.
module tb_conv2_sched;

    typedef struct {
        int cyc;
        int a;
        int b;
    } ev_t;

    localparam int NC = 2048;

    int sz_t [2] = '{5, 4};
    int kk_t [2] = '{3, 1};

    logic clk = 1'b0;
    logic reset;
    logic start_v [2];
    logic out_ready_v [2];
    logic busy_v [2], done_v [2], rd_v [2], mac_v [2], mf_v [2], we_v [2];
    logic [15:0] img_v [2], ker_v [2], oad_v [2];

    logic [4:0] img_a;
    logic [3:0] ker_a, oad_a;
    logic [3:0] img_b, oad_b;
    logic [0:0] ker_b;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   rdy [2][NC];
    ev_t  rd_q [2][$];
    ev_t  mac_q [2][$];
    ev_t  we_q [2][$];
    ev_t  done_q [2][$];
    ev_t  mon_ev;
    logic done_prev [2];

    always #5 clk = ~clk;

    conv2_sched #(.SIZE(5), .SIZEKer(3), .WIDTH_BIT(16)) dut_a (
        .clock(clk), .reset(reset), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .rd_en(rd_v[0]), .img_addr(img_a), .ker_addr(ker_a), .mac_en(mac_v[0]),
        .mac_first(mf_v[0]), .out_we(we_v[0]), .out_addr(oad_a), .out_ready(out_ready_v[0])
    );

    conv2_sched #(.SIZE(4), .SIZEKer(1), .WIDTH_BIT(16)) dut_b (
        .clock(clk), .reset(reset), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .rd_en(rd_v[1]), .img_addr(img_b), .ker_addr(ker_b), .mac_en(mac_v[1]),
        .mac_first(mf_v[1]), .out_we(we_v[1]), .out_addr(oad_b), .out_ready(out_ready_v[1])
    );

    assign img_v[0] = 16'(img_a);
    assign ker_v[0] = 16'(ker_a);
    assign oad_v[0] = 16'(oad_a);
    assign img_v[1] = 16'(img_b);
    assign ker_v[1] = 16'(ker_b);
    assign oad_v[1] = 16'(oad_b);

    function automatic ev_t mk(input int c, input int a, input int b);
        ev_t e;
        e.cyc = c;
        e.a   = a;
        e.b   = b;
        return e;
    endfunction

    function automatic void chk(input string nm, input int d, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d want %0d (cyc %0d)", nm, d, act, exp, cyc);
        end
    endfunction

    // Edge counter; a cycle observed at negedge carries the number of edges seen so far
    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) out_ready_v[d] = (cyc < NC) ? rdy[d][cyc] : 1'b1;
    end

    // Reference timeline: taps read back-to-back, one wait cycle, then write until accepted
    task automatic model_run(input int d, input int e);
        int k, ou, base, w;
        k    = kk_t[d];
        ou   = sz_t[d] - k + 1;
        base = e;
        for (int r = 0; r < ou; r++) begin
            for (int c = 0; c < ou; c++) begin
                for (int i = 0; i < k; i++) begin
                    for (int j = 0; j < k; j++) begin
                        rd_q[d].push_back(mk(base + i * k + j, (r + i) * sz_t[d] + (c + j), i * k + j));
                        mac_q[d].push_back(mk(base + i * k + j + 1, int'(i == 0 && j == 0), 0));
                    end
                end
                w = base + k * k + 1;
                while (w < NC && !rdy[d][w]) begin
                    we_q[d].push_back(mk(w, r * ou + c, 0));
                    w++;
                end
                we_q[d].push_back(mk(w, r * ou + c, 1));
                base = w + 1;
            end
        end
        done_q[d].push_back(mk(base, 0, 0));
    endtask

    task automatic set_rdy(input int d, input int mode, input int e);
        for (int k = e; k < NC; k++) rdy[d][k] = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (mode == 2) begin
            for (int s = 0; s < 5; s++) if (e + 54 + s < NC) rdy[d][e + 54 + s] = 1'b0;
        end
    endtask

    task automatic do_start(input int d, input int mode, output int e);
        @(posedge clk);
        #1;
        e = cyc + 1;
        set_rdy(d, mode, e);
        model_run(d, e);
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        chk("start_busy", d, int'(busy_v[d]), 1);
        chk("start_done_low", d, int'(done_v[d]), 0);
        chk("start_rd_en", d, int'(rd_v[d]), 1);
    endtask

    task automatic finish_run(input int d, input int e, output int len);
        int n;
        n = 0;
        while (!done_v[d] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", d, int'(done_v[d]), 1);
        len = cyc - e;
        @(negedge clk);
        #1;
        chk("rd_left", d, rd_q[d].size(), 0);
        chk("mac_left", d, mac_q[d].size(), 0);
        chk("we_left", d, we_q[d].size(), 0);
        chk("done_left", d, done_q[d].size(), 0);
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_busy"}, d, int'(busy_v[d]), 0);
        chk({tag, "_done"}, d, int'(done_v[d]), 0);
        chk({tag, "_rd_en"}, d, int'(rd_v[d]), 0);
        chk({tag, "_mac_en"}, d, int'(mac_v[d]), 0);
        chk({tag, "_mac_first"}, d, int'(mf_v[d]), 0);
        chk({tag, "_out_we"}, d, int'(we_v[d]), 0);
        chk({tag, "_img_addr"}, d, int'(img_v[d]), 0);
        chk({tag, "_ker_addr"}, d, int'(ker_v[d]), 0);
        chk({tag, "_out_addr"}, d, int'(oad_v[d]), 0);
    endtask

    // Monitor: every strobe the DUT raises must match the head of its expectation queue
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                if (rd_v[d]) begin
                    chk("rd_expected", d, int'(rd_q[d].size() != 0), 1);
                    if (rd_q[d].size() != 0) begin
                        mon_ev = rd_q[d].pop_front();
                        chk("rd_cycle", d, cyc, mon_ev.cyc);
                        chk("img_addr", d, int'(img_v[d]), mon_ev.a);
                        chk("ker_addr", d, int'(ker_v[d]), mon_ev.b);
                        chk("busy_in_read", d, int'(busy_v[d]), 1);
                    end
                end else begin
                    chk("img_addr_idle", d, int'(img_v[d]), 0);
                    chk("ker_addr_idle", d, int'(ker_v[d]), 0);
                end
                if (mac_v[d]) begin
                    chk("mac_expected", d, int'(mac_q[d].size() != 0), 1);
                    if (mac_q[d].size() != 0) begin
                        mon_ev = mac_q[d].pop_front();
                        chk("mac_cycle", d, cyc, mon_ev.cyc);
                        chk("mac_first", d, int'(mf_v[d]), mon_ev.a);
                    end
                end else begin
                    chk("mac_first_idle", d, int'(mf_v[d]), 0);
                end
                if (we_v[d]) begin
                    chk("we_expected", d, int'(we_q[d].size() != 0), 1);
                    if (we_q[d].size() != 0) begin
                        mon_ev = we_q[d].pop_front();
                        chk("we_cycle", d, cyc, mon_ev.cyc);
                        chk("out_addr", d, int'(oad_v[d]), mon_ev.a);
                        chk("handshake", d, int'(out_ready_v[d]), mon_ev.b);
                    end
                end else begin
                    chk("out_addr_idle", d, int'(oad_v[d]), 0);
                end
                if (done_v[d] && !done_prev[d]) begin
                    chk("done_expected", d, int'(done_q[d].size() != 0), 1);
                    if (done_q[d].size() != 0) begin
                        mon_ev = done_q[d].pop_front();
                        chk("done_cycle", d, cyc, mon_ev.cyc);
                        chk("busy_at_done", d, int'(busy_v[d]), 0);
                    end
                end
            end
        end
        for (int d = 0; d < 2; d++) done_prev[d] = done_v[d];
    end

    initial begin
        int e, len;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_v[d]     = 1'b0;
            out_ready_v[d] = 1'b1;
            done_prev[d]   = 1'b0;
            set_rdy(d, 0, 0);
        end
        #3;
        chk_zero(0, "reset");
        chk_zero(1, "reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 5x5 image, 3x3 kernel, always ready
        do_start(0, 0, e);
        finish_run(0, e, len);
        chk("len_nominal", 0, len, 99);

        // Restart from DONE with random back-pressure
        do_start(0, 1, e);
        finish_run(0, e, len);

        // Five stall cycles on window 4's write
        do_start(0, 2, e);
        finish_run(0, e, len);
        chk("len_stall", 0, len, 104);

        // Start pulsed during window 3 reads is ignored
        do_start(0, 0, e);
        while (cyc < e + 35) @(posedge clk);
        #1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        finish_run(0, e, len);
        chk("len_start_ignored", 0, len, 99);

        // Reset during window 2, tap 4
        do_start(0, 0, e);
        while (cyc < e + 26) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rd_q[d].delete();
            mac_q[d].delete();
            we_q[d].delete();
            done_q[d].delete();
        end
        #1;
        chk_zero(0, "midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_start(0, 0, e);
        finish_run(0, e, len);
        chk("len_after_reset", 0, len, 99);

        // 4x4 image, 1x1 kernel
        do_start(1, 0, e);
        finish_run(1, e, len);
        chk("len_k1", 1, len, 48);
        do_start(1, 1, e);
        finish_run(1, e, len);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv2_sched.md
# conv2_sched

Control sequencer for the 2-D convolution datapath. It walks every valid kernel window of a SIZE×SIZE input image in raster order and, for each window, walks the SIZEKer×SIZEKer taps. For each tap it issues image and kernel memory read addresses and MAC control strobes. It writes each finished window result to the output buffer under a ready/valid handshake. It sits between the top-level start/done interface and the image memory, kernel memory, MAC and output memory. It replaces free-running iteration inside conv2.

## Interface
- SIZE, 320, input image edge length; SIZE ≥ SIZEKer
- SIZEKer, 3, kernel edge length; ≥ 1
- WIDTH_BIT, 16, data width; no sequencing effect, passed through for consistency
- OUT = SIZE-SIZEKer+1 (local): output edge length
- IMG_AW = max(1,$clog2(SIZE*SIZE)), KER_AW = max(1,$clog2(SIZEKer*SIZEKer)), OUT_AW = max(1,$clog2(OUT*OUT)) (local)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; all state and outputs clear immediately
- start  in  1  request a full convolution; sampled only in IDLE or DONE
- busy  out  1  high from cycle after accepted start until last write accepted
- done  out  1  level; high in DONE, cleared by accepted start or reset
- rd_en  out  1  image/kernel read strobe, 1-cycle read latency
- img_addr  out  IMG_AW  (r+i)*SIZE + (c+j)
- ker_addr  out  KER_AW  i*SIZEKer + j
- mac_en  out  1  product valid at MAC (rd_en delayed 1 cycle)
- mac_first  out  1  with mac_en: load product instead of accumulating (tap 0)
- out_we  out  1  window result valid at MAC output
- out_addr  out  OUT_AW  r*OUT + c
- out_ready  in  1  output buffer accepts; write completes on out_we & out_ready

## Operation
- Counters: window r, c in 0..OUT-1; tap i, j in 0..SIZEKer-1. j is innermost, then i, then c, then r.
- States:
  - IDLE: all outputs 0. start=1 → READ with r=c=i=j=0.
  - READ: rd_en=1 for exactly SIZEKer² cycles, one tap per cycle; addresses are combinational from counters. After the last tap (i=j=SIZEKer-1) → WAIT, taps reset to 0.
  - WAIT: 1 cycle. rd_en=0. mac_en=1 for the last tap.
  - WRITE: out_we=1 and out_addr held stable until out_ready=1. On handshake:
    - if r=c=OUT-1 → DONE;
    - else advance c, wrapping to 0 and incrementing r at c=OUT-1, then → READ.
  - DONE: done=1, busy=0. start=1 → READ from window 0 and done drops the same edge. Otherwise stay.
- mac_en/mac_first are registered copies of rd_en/(tap==0). mac_en is therefore high in cycles 2..SIZEKer²+1 of each window. The MAC result is registered and valid in WRITE.
- Addresses are don't-care (driven 0) when rd_en=0. out_addr is 0 when out_we=0.
- start while busy: ignored, no effect on counters.
- SIZEKer=1: READ lasts 1 cycle; mac_first set on every window.
- SIZE=SIZEKer: single window, out_addr=0.

## Timing
- Reset values: busy=0, done=0, rd_en=0, mac_en=0, mac_first=0, out_we=0, all addresses 0, state IDLE.
- Start accepted at edge E: READ, rd_en, busy all high from E.
- Per window, with out_ready=1: SIZEKer²+2 cycles. Each out_ready-low cycle in WRITE adds one cycle.
- Total, with out_ready=1: done rises at E + OUT²·(SIZEKer²+2) edges.
- Windows are not overlapped; no read for window n+1 is issued before window n's write handshake.
- Reset mid-operation: returns to IDLE asynchronously, with no partial write. The next start restarts from window 0.

## Test plan
- SIZE=5, SIZEKer=3, out_ready=1, one start pulse:
  - window 0 img_addr 0,1,2,5,6,7,10,11,12 with ker_addr 0..8;
  - mac_first only on first mac_en;
  - out_addr 0..8 in order;
  - done high 99 cycles after start edge, busy low the same cycle.
- Same config, last window (r=c=2): img_addr 12,13,14,17,18,19,22,23,24; out_addr 8 precedes done.
- Same config, out_ready low for 5 cycles during window 4: out_we and out_addr=4 held, no rd_en meanwhile, done at 104 cycles.
- start pulsed in READ of window 3: ignored, sequence unchanged. start in DONE: done drops, window 0 restarts.
- reset asserted in READ of window 2 tap 4: all outputs 0 immediately, no out_we. New start reproduces the full 99-cycle run from out_addr 0.
- SIZE=4, SIZEKer=1: 16 windows, 3 cycles each, img_addr equals out_addr 0..15, every mac_en has mac_first=1, done at 48 cycles.
